// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared encodings and width limits for updown_counter
//
// Purpose: direction and boundary-mode encodings plus the legal WIDTH range,
// shared by the counter top level and its incrementer/decrementer.
// Ports: none (package).

package updown_counter_pkg;

  // Direction encodings for the up input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Boundary-mode encodings for the sat input.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Legal range for the WIDTH parameter.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/updown_counter_addsub.sv
// rtl/updown_counter_addsub.sv - combinational WIDTH-bit incrementer/decrementer
//
// Purpose: produces a+1 or a-1 modulo 2**WIDTH; any carry or borrow out of
// WIDTH bits is discarded because boundaries are decided by compares upstream.
// Ports:
//   a      input  WIDTH  operand (current count)
//   dir    input  1      DIR_UP = increment, DIR_DN = decrement
//   result output WIDTH  a +/- 1

module addsub_nbit
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (dir == DIR_UP) begin
      result = a + WIDTH'(1);
    end else begin
      result = a - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with runtime bound, load, wrap/saturate
//
// Purpose: general-purpose counting primitive. Counts between 0 and max_val
// inclusive, either wrapping or saturating at the bounds, with a one-cycle
// terminal-count pulse and a sticky boundary flag.
// Ports:
//   clk      input  1      rising-edge clock
//   rst      input  1      synchronous active-high reset, highest priority
//   en       input  1      count enable
//   up       input  1      1 = increment, 0 = decrement
//   sat      input  1      1 = saturate, 0 = wrap
//   load     input  1      parallel load strobe, beats en
//   load_val input  WIDTH  value to load (clamped to max_val)
//   max_val  input  WIDTH  inclusive upper bound, sampled every cycle
//   cnt      output WIDTH  registered count
//   tc       output 1      registered terminal-count pulse
//   ovf      output 1      registered sticky boundary flag
//   zero     output 1      combinational cnt == 0

module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("updown_counter: WIDTH out of range");
  end

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;

  logic [WIDTH-1:0] step_val;
  logic             at_or_above_max;
  logic             above_max;
  logic             at_zero;

  logic [WIDTH-1:0] cnt_d;
  logic             tc_d;
  logic             ovf_d;

  addsub_nbit #(.WIDTH(WIDTH)) u_addsub (
    .a      (cnt_q),
    .dir    (up),
    .result (step_val)
  );

  assign at_or_above_max = (cnt_q >= max_val);
  assign above_max       = (cnt_q > max_val);
  assign at_zero         = (cnt_q == '0);

  // Counting next state; load and reset are layered on top in the register.
  // step_val is only selected where the compares guarantee no wrap-around.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (en) begin
      if (up == DIR_UP) begin
        if (!at_or_above_max) begin
          cnt_d = step_val;
        end else begin
          cnt_d = (sat == MODE_SAT) ? max_val : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        // A count left above a lowered bound is pulled back to the bound
        // without being treated as a boundary crossing.
        if (above_max) begin
          cnt_d = max_val;
        end else if (!at_zero) begin
          cnt_d = step_val;
        end else begin
          cnt_d = (sat == MODE_SAT) ? '0 : max_val;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      cnt_q <= (load_val > max_val) ? max_val : load_val;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - self-checking bench for updown_counter (WIDTH=4)

module tb_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         sat = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = '0;
  logic [W-1:0] cnt;
  logic         tc;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers following the operation rules.
  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .cnt      (cnt),
    .tc       (tc),
    .ovf      (ovf),
    .zero     (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: counts live in the range 0..mv; leaving that range at
  // either end is a boundary event; a count above mv going down snaps to mv.
  task automatic model_edge(input int r, input int l, input int e, input int u,
                            input int s, input int lv, input int mv);
    if (r != 0) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0;
    end else if (l != 0) begin
      m_cnt = (lv < mv) ? lv : mv; m_tc = 0; m_ovf = 0;
    end else if (e == 0) begin
      m_tc = 0;
    end else if (u != 0) begin
      if (m_cnt + 1 <= mv) begin
        m_cnt = m_cnt + 1; m_tc = 0;
      end else begin
        m_cnt = (s != 0) ? mv : 0; m_tc = 1; m_ovf = 1;
      end
    end else begin
      if (m_cnt > mv) begin
        m_cnt = mv; m_tc = 0;
      end else if (m_cnt - 1 >= 0) begin
        m_cnt = m_cnt - 1; m_tc = 0;
      end else begin
        m_cnt = (s != 0) ? 0 : mv; m_tc = 1; m_ovf = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare on the falling edge.
  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic s, input int lv, input int mv, input string tag);
    rst = r; load = l; en = e; up = u; sat = s;
    load_val = W'(lv); max_val = W'(mv);
    @(posedge clk);
    model_edge(int'(r), int'(l), int'(e), int'(u), int'(s), lv, mv);
    @(negedge clk);
    chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    chk({tag, ".tc"},   32'(tc),   32'(m_tc));
    chk({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
    chk({tag, ".zero"}, 32'(zero), (m_cnt == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset for two cycles.
    step(1, 0, 0, 1, 0, 0, 9, "reset");
    step(1, 0, 0, 1, 0, 0, 9, "reset");
    chk("reset.cnt_const", 32'(cnt), 32'd0);
    chk("reset.zero_const", 32'(zero), 32'd1);

    // Up-wrap at max_val=9: 1..9, 0, 1.
    for (int i = 0; i < 11; i++) step(0, 0, 1, 1, 0, 0, 9, "upwrap");
    chk("upwrap.cnt_const", 32'(cnt), 32'd1);
    chk("upwrap.ovf_const", 32'(ovf), 32'd1);

    // Up-saturate at max_val=5, then drop en.
    step(0, 1, 0, 1, 1, 0, 5, "upsat_load");
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 0, 5, "upsat");
    chk("upsat.cnt_const", 32'(cnt), 32'd5);
    chk("upsat.tc_const", 32'(tc), 32'd1);
    step(0, 0, 0, 1, 1, 0, 5, "upsat_hold");
    chk("upsat_hold.tc_const", 32'(tc), 32'd0);

    // Down-wrap from 2 with max_val=9: 1, 0, 9, 8.
    step(0, 1, 0, 0, 0, 2, 9, "dnwrap_load");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 9, "dnwrap");
    chk("dnwrap.cnt_const", 32'(cnt), 32'd8);

    // Down-saturate from 2: 1, 0, 0, 0.
    step(0, 1, 0, 0, 1, 2, 9, "dnsat_load");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0, 9, "dnsat");
    chk("dnsat.tc_const", 32'(tc), 32'd1);

    // Load beats en, load value clamped, ovf cleared.
    step(0, 1, 1, 1, 0, 12, 9, "loadclamp");
    chk("loadclamp.cnt_const", 32'(cnt), 32'd9);
    chk("loadclamp.ovf_const", 32'(ovf), 32'd0);

    // Runtime bound change below the current count.
    step(0, 1, 0, 1, 0, 8, 9, "bound_load");
    step(0, 0, 1, 1, 0, 0, 3, "bound_up");
    chk("bound_up.tc_const", 32'(tc), 32'd1);
    step(0, 1, 0, 0, 0, 8, 9, "bound_load2");
    step(0, 0, 1, 0, 0, 0, 3, "bound_dn");
    chk("bound_dn.cnt_const", 32'(cnt), 32'd3);

    // Reset overrides load and en mid-count.
    step(0, 1, 0, 1, 0, 6, 9, "rstmid_load");
    step(1, 1, 1, 1, 0, 7, 9, "rstmid");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 9, "rstmid_resume");

    // max_val=0: stays at 0 with tc on every enabled cycle.
    for (int i = 0; i < 3; i++) step(0, 0, 1, i[0], i[1], 0, 0, "max0");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic r, l, e, u, s;
      int lv, mv;
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 8);
      u  = 1'($urandom);
      s  = 1'($urandom);
      lv = int'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       mv = 0;
        1:       mv = 15;
        default: mv = int'($urandom_range(0, 15));
      endcase
      step(r, l, e, u, s, lv, mv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
